// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS phase path.
package dds_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } dds_state_e;

  // Default widths, also used by the waveform LUT stage.
  localparam int unsigned DdsPhaseW = 32;
  localparam int unsigned DdsOutW   = 12;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form (tap bits 15, 13, 12, 10).
  localparam logic [15:0] LfsrTaps = 16'hB400;
  localparam logic [15:0] LfsrSeed = 16'hACE1;

  // Number of dither bits: the truncated-away width, capped at the LFSR width.
  function automatic int unsigned dither_width(int unsigned phase_w, int unsigned out_w);
    int unsigned w;
    w = phase_w - out_w;
    return (w > 16) ? 16 : w;
  endfunction

endpackage

// File: rtl/dds_lfsr16.sv
// 16-bit maximal-length LFSR used to dither phase truncation.
module dds_lfsr16
  import dds_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift left, feeding back the XOR of the tapped bits.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
  end

  // State register, seeded on reset so it never sits at all-zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LfsrSeed;
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator: accumulates the active FTW while DelCE is high and emits a
// truncated, offset phase word. FTW updates are deferred to accumulator wrap.
// Optional truncation dither is enabled by defining DDS_PHASE_DITHER_EN.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = DdsPhaseW,
  parameter int unsigned OUT_W   = DdsOutW
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CE,
  input  logic               DelCE,
  input  logic [PHASE_W-1:0] FTW,
  input  logic               FTW_LD,
  input  logic [OUT_W-1:0]   POFF,
  input  logic               SYNC_CLR,
  output logic [OUT_W-1:0]   PHASE_OUT,
  output logic               PHASE_VLD,
  output logic               WRAP
);

  dds_state_e         state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] ftw_sh_q, ftw_sh_d;
  logic [PHASE_W-1:0] ftw_act_q, ftw_act_d;
  // Carry of the accumulate that produced acc_q, so WRAP lines up with its sample.
  logic               carry_q, carry_d;
  logic [OUT_W-1:0]   phase_q, phase_d;
  logic               vld_q, vld_d;
  logic               wrap_q, wrap_d;

  logic [PHASE_W:0]   sum;
  logic [PHASE_W-1:0] acc_dith;

  assign sum = {1'b0, acc_q} + {1'b0, ftw_act_q};

`ifdef DDS_PHASE_DITHER_EN
  localparam int unsigned DitherW    = dither_width(PHASE_W, OUT_W);
  localparam logic [15:0] DitherMask = 16'((32'd1 << DitherW) - 32'd1);

  logic [15:0] lfsr;

  dds_lfsr16 u_lfsr (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .en_i    (CE && (state_q == StRun)),
    .state_o (lfsr)
  );

  // Dither carry out of the top bit is dropped; WRAP only follows the plain sum.
  assign acc_dith = acc_q + PHASE_W'(lfsr & DitherMask);
`else
  assign acc_dith = acc_q;
`endif

  // Next-state for the FSM, accumulator and FTW shadow/active registers.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ftw_act_d = ftw_act_q;
    carry_d   = 1'b0;
    ftw_sh_d  = FTW_LD ? FTW : ftw_sh_q;

    if (SYNC_CLR) begin
      // A coincident load bypasses the shadow and takes effect immediately.
      acc_d     = '0;
      ftw_act_d = FTW_LD ? FTW : ftw_sh_q;
    end else begin
      case (state_q)
        StIdle: begin
          acc_d     = '0;
          ftw_act_d = ftw_sh_q;
          if (DelCE) state_d = StRun;
        end
        StRun: begin
          if (DelCE) begin
            acc_d   = sum[PHASE_W-1:0];
            carry_d = sum[PHASE_W];
            // Pre-edge shadow is used, so a load landing on a wrap waits one more wrap.
            if (sum[PHASE_W] && (ftw_sh_q != ftw_act_q)) ftw_act_d = ftw_sh_q;
          end else begin
            state_d = StIdle;
            acc_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output stage computed from the registered accumulator.
  always_comb begin
    phase_d = acc_dith[PHASE_W-1 -: OUT_W] + POFF;
    vld_d   = (state_q == StRun);
    wrap_d  = carry_q;
  end

  // All state advances only on CE; reset clears outputs asynchronously.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      ftw_sh_q  <= '0;
      ftw_act_q <= '0;
      carry_q   <= 1'b0;
      phase_q   <= '0;
      vld_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ftw_sh_q  <= ftw_sh_d;
      ftw_act_q <= ftw_act_d;
      carry_q   <= carry_d;
      phase_q   <= phase_d;
      vld_q     <= vld_d;
      wrap_q    <= wrap_d;
    end
  end

  assign PHASE_OUT = phase_q;
  assign PHASE_VLD = vld_q;
  assign WRAP      = wrap_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Directed bench for dds_phase_acc with default widths (PHASE_W=32, OUT_W=12).
module tb_dds_phase_acc;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        del_ce;
  logic [31:0] ftw;
  logic        ftw_ld;
  logic [11:0] poff;
  logic        sync_clr;
  logic [11:0] phase_out;
  logic        phase_vld;
  logic        wrap;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  dds_phase_acc u_dut (
    .CLK       (clk),
    .RSTn      (rst_n),
    .CE        (ce),
    .DelCE     (del_ce),
    .FTW       (ftw),
    .FTW_LD    (ftw_ld),
    .POFF      (poff),
    .SYNC_CLR  (sync_clr),
    .PHASE_OUT (phase_out),
    .PHASE_VLD (phase_vld),
    .WRAP      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [11:0] p, input logic v,
                           input logic w);
    check({tag, ".phase"}, {20'd0, phase_out}, {20'd0, p});
    check({tag, ".vld"}, {31'd0, phase_vld}, {31'd0, v});
    check({tag, ".wrap"}, {31'd0, wrap}, {31'd0, w});
  endtask

  initial begin
    rst_n    = 1'b0;
    ce       = 1'b1;
    del_ce   = 1'b0;
    ftw      = '0;
    ftw_ld   = 1'b0;
    poff     = '0;
    sync_clr = 1'b0;
    #12;
    check_out("reset", 12'h000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();

    // Load FTW = 1/16 turn while idle, then start.
    ftw    = 32'h1000_0000;
    ftw_ld = 1'b1;
    tick();
    ftw_ld = 1'b0;
    tick();
    check_out("idle", 12'h000, 1'b0, 1'b0);
    del_ce = 1'b1;
    tick();
    check("start.vld_lat", {31'd0, phase_vld}, 32'd0);
    tick();
    check_out("first", 12'h000, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check_out("ramp", 12'(i * 'h100), 1'b1, 1'b0);
    end
    tick();
    check_out("wrap1", 12'h000, 1'b1, 1'b1);

    // Mid-run FTW load: step stays 0x100 until the next wrap.
    ftw    = 32'h2000_0000;
    ftw_ld = 1'b1;
    tick();
    ftw_ld = 1'b0;
    check_out("ld_hold", 12'h100, 1'b1, 1'b0);
    for (int i = 2; i < 16; i++) begin
      tick();
      check("ld_ramp", {20'd0, phase_out}, 32'(i * 'h100));
    end
    tick();
    check_out("wrap2", 12'h000, 1'b1, 1'b1);
    tick();
    check_out("new_step1", 12'h200, 1'b1, 1'b0);
    tick();
    check_out("new_step2", 12'h400, 1'b1, 1'b0);

    // CE gap: everything freezes, no step lost or repeated.
    ce = 1'b0;
    tick();
    check_out("ce_hold1", 12'h400, 1'b1, 1'b0);
    tick();
    check_out("ce_hold2", 12'h400, 1'b1, 1'b0);
    ce = 1'b1;
    tick();
    check_out("ce_resume", 12'h600, 1'b1, 1'b0);

    // SYNC_CLR together with FTW_LD: new FTW applies immediately from zero.
    ftw      = 32'h1000_0000;
    ftw_ld   = 1'b1;
    sync_clr = 1'b1;
    poff     = 12'h010;
    tick();
    ftw_ld   = 1'b0;
    sync_clr = 1'b0;
    check_out("clr_edge", 12'h810, 1'b1, 1'b0);
    tick();
    check_out("clr_ld0", 12'h010, 1'b1, 1'b0);
    tick();
    check_out("clr_ld1", 12'h110, 1'b1, 1'b0);
    tick();
    check_out("pre_clr", 12'h210, 1'b1, 1'b0);

    // Plain SYNC_CLR mid-run; state stays RUN.
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    check_out("clr_edge2", 12'h310, 1'b1, 1'b0);
    tick();
    check_out("clr0", 12'h010, 1'b1, 1'b0);
    tick();
    check_out("clr1", 12'h110, 1'b1, 1'b0);

    // FTW_LD landing on the wrap edge: the old step survives that wrap.
    for (int n = 1; n <= 13; n++) begin
      tick();
      check("to_wrap", {20'd0, phase_out}, 32'((n + 1) * 'h100 + 'h10));
    end
    ftw    = 32'h4000_0000;
    ftw_ld = 1'b1;
    tick();
    ftw_ld = 1'b0;
    check_out("ld_at_wrap", 12'hF10, 1'b1, 1'b0);
    tick();
    check_out("wrap3", 12'h010, 1'b1, 1'b1);
    tick();
    check_out("old_step", 12'h110, 1'b1, 1'b0);

    // DelCE drop and restart.
    del_ce = 1'b0;
    tick();
    check_out("stop_edge", 12'h210, 1'b1, 1'b0);
    tick();
    check("stop.vld", {31'd0, phase_vld}, 32'd0);
    del_ce = 1'b1;
    tick();
    check("restart.vld_lat", {31'd0, phase_vld}, 32'd0);
    tick();
    check_out("restart0", 12'h010, 1'b1, 1'b0);
    tick();
    check_out("restart1", 12'h410, 1'b1, 1'b0);

    // FTW = 0: phase holds, valid stays up, no wrap.
    ftw      = 32'h0;
    ftw_ld   = 1'b1;
    sync_clr = 1'b1;
    tick();
    ftw_ld   = 1'b0;
    sync_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("ftw0", 12'h010, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-run.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 12'h000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
